// File: rtl/sram_port_pkg.sv
// Shared constants and helpers for the SRAM RW port controller.
package sram_port_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  localparam logic CSB_IDLE = 1'b1;
  localparam int   RD_LAT   = 2;

  // Number of bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response buffer: synchronous FIFO with async reset and occupancy count.
module sram_rsp_fifo
  import sram_port_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head_data,
  output logic                       not_empty,
  output logic [clog2(RSP_DEPTH):0]  count
);

  localparam int PTR_W = clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  // Head reads as zero while empty so the output is clean out of reset.
  assign head_data = not_empty ? mem[rd_ptr] : '0;

  // Storage write; data entries carry no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally (power-of-2 depth); count tracks push/pop balance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Credit logic upstream must make a push into a full buffer impossible.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && (count == CNT_W'(RSP_DEPTH))));

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Initiator for one OpenRAM RW port: registered pin issue, fixed-latency read
// capture and a credit-managed response buffer.
module sram_rw_port_ctrl
  import sram_port_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                       clk0,
  input  logic                       rst0,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       csb0,
  output logic                       web0,
  output logic [ADDR_WIDTH-1:0]      addr0,
  output logic [DATA_WIDTH-1:0]      din0,
  input  logic [DATA_WIDTH-1:0]      dout0,
  output logic [clog2(RSP_DEPTH):0]  rd_pending
);

  localparam int OCC_W = clog2(RSP_DEPTH) + 1;

  logic              accept;
  logic              issue_rd;
  logic [RD_LAT-1:0] rd_vld_p;   // bit 0 = S1, bit RD_LAT-1 = S2
  logic [OCC_W-1:0]  buf_count;
  logic [OCC_W-1:0]  occupancy;
  logic              push;
  logic              pop;

  // A credit is held from read accept until the consumer pops the response,
  // so the buffer can always absorb every read still in the pipe.
  assign req_ready  = !rst0 && (occupancy < OCC_W'(RSP_DEPTH));
  assign accept     = req_valid && req_ready;
  assign issue_rd   = accept && (req_we == OP_READ);
  assign rd_pending = occupancy;
  assign push       = rd_vld_p[RD_LAT-1];
  assign pop        = rsp_valid && rsp_ready;

  // Issue registers driving the SRAM pins; address/data hold when idle.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      csb0  <= CSB_IDLE;
      web0  <= 1'b1;
      addr0 <= '0;
      din0  <= '0;
    end else if (accept) begin
      csb0  <= ~CSB_IDLE;
      web0  <= (req_we == OP_WRITE) ? 1'b0 : 1'b1;
      addr0 <= req_addr;
      din0  <= req_wdata;
    end else begin
      csb0  <= CSB_IDLE;
      web0  <= 1'b1;
    end
  end

  // Read-tracking pipe: S1 at accept, S2 while the macro reads, then capture.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) rd_vld_p <= '0;
    else      rd_vld_p <= {rd_vld_p[RD_LAT-2:0], issue_rd};
  end

  // Occupancy = reads in flight + buffered responses.
  always_comb begin
    occupancy = buf_count;
    for (int i = 0; i < RD_LAT; i++) begin
      occupancy = occupancy + OCC_W'(rd_vld_p[i]);
    end
  end

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk0),
    .rst       (rst0),
    .push      (push),
    .push_data (dout0),
    .pop       (pop),
    .head_data (rsp_rdata),
    .not_empty (rsp_valid),
    .count     (buf_count)
  );

endmodule
